// File: rtl/seq_mul_add_acc.sv
// Sequential multiply-add: result = a*b + addend (or running acc), one multiplier bit per cycle.
// Valid/ready handshakes on both sides; result and acc register are 2*W bits, wrapping.
module seq_mul_add_acc #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [2*W-1:0]   addend,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   result,
  output logic             busy
);

  localparam int unsigned RW = 2 * W;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [RW-1:0]     part_q, part_d;
  logic [RW-1:0]     acc_q, acc_d;
  logic [RW-1:0]     res_q, res_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  shamt;
  logic [RW-1:0]     a_ext;

  assign a_ext = {{W{1'b0}}, a_q};
  // Counter runs W..1, so the shift walks 0..W-1 as multiplier bits are consumed.
  assign shamt = CNT_W'(W) - cnt_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (acc_clr) acc_d = '0;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          // A coinciding clear wins, so an accumulate beat starts from zero.
          part_d  = acc_mode ? (acc_clr ? '0 : acc_q) : addend;
          cnt_d   = CNT_W'(W);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (b_q[0]) part_d = part_q + (a_ext << shamt);
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          res_d   = part_d;
          acc_d   = part_d;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StBusy);
  assign out_valid = (state_q == StDone);
  assign result    = res_q;

endmodule
